// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared geometry constants and scan FSM state type for the score-bar reader
package score_pkg;

  localparam int BAR_W = 55;
  localparam int BAR_H = 25;
  localparam int BAR_N = BAR_W * BAR_H;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/frame_edge_sync.sv
// rtl/frame_edge_sync.sv - three-flop synchronizer with rising-edge pulse for the frame tick
module frame_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic start_o
);

  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  // live_q[k] says stage k+1 holds a real sample rather than its reset value, so a
  // tick already high at reset release is not mistaken for a rising edge.
  logic [2:0] live_q;

  // Shift the asynchronous tick through the synchronizer chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      live_q <= 3'b000;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      live_q <= {live_q[1:0], 1'b1};
    end
  end

  assign start_o = s2_q & ~s3_q & live_q[2];

endmodule

// File: rtl/score_bar_reader.sv
// rtl/score_bar_reader.sv - streams a snapshotted score-bar bitmap pixel by pixel on each frame tick
module score_bar_reader
  import score_pkg::scan_state_t;
  import score_pkg::IDLE;
  import score_pkg::SCAN;
#(
  parameter int BAR_W = score_pkg::BAR_W,
  parameter int BAR_H = score_pkg::BAR_H
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [BAR_W*BAR_H-1:0] score_bar_left,
  input  logic                   pix_ready,
  output logic                   pix_valid,
  output logic                   pix_data,
  output logic [5:0]             pix_x,
  output logic [4:0]             pix_y,
  output logic                   pix_last,
  output logic                   busy,
  output logic [7:0]             overrun_cnt
);

  localparam int         N      = BAR_W * BAR_H;
  localparam int         IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [5:0] X_LAST = 6'(BAR_W - 1);
  localparam logic [4:0] Y_LAST = 5'(BAR_H - 1);

  scan_state_t      state_q, state_d;
  logic [5:0]       x_q, x_d;
  logic [4:0]       y_q, y_d;
  // Running linear index y*BAR_W + x, kept alongside x/y to avoid a multiplier
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [N-1:0]     snap_q;
  logic             load_snap;
  logic             start;
  logic             in_scan;
  logic             at_last;

  frame_edge_sync u_sync (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .async_i (frame_clk),
    .start_o (start)
  );

  assign in_scan = (state_q == SCAN);
  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

  // Scan sequencing: start in IDLE, advance on handshake, count starts lost during SCAN
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    idx_d     = idx_q;
    ovr_d     = ovr_q;
    load_snap = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          x_d       = '0;
          y_d       = '0;
          idx_d     = '0;
          load_snap = 1'b1;
        end
      end
      SCAN: begin
        // A start landing on the final handshake is also dropped, not queued
        if (start && (ovr_q != 8'hFF)) begin
          ovr_d = ovr_q + 8'd1;
        end
        if (pix_ready) begin
          if (at_last) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            idx_d   = '0;
          end else if (x_q == X_LAST) begin
            x_d   = '0;
            y_d   = y_q + 5'd1;
            idx_d = idx_q + 1'b1;
          end else begin
            x_d   = x_q + 6'd1;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, position and overrun registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  // Bitmap snapshot, captured once at scan start so mid-scan input changes are invisible
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      snap_q <= '0;
    end else if (load_snap) begin
      snap_q <= score_bar_left;
    end
  end

  assign pix_valid   = in_scan;
  assign busy        = in_scan;
  assign pix_x       = in_scan ? x_q : 6'd0;
  assign pix_y       = in_scan ? y_q : 5'd0;
  assign pix_data    = in_scan & snap_q[idx_q];
  assign pix_last    = in_scan & at_last;
  assign overrun_cnt = ovr_q;

endmodule
